// File: rtl/mgr_stu_arbiter_if.sv
// Bundles the per-Manager upstream wires and the single Stack Bus upstream port.
// The master modport is the arbiter's view; slave is the Managers/upstream side.
interface mgr_stu_arbiter_if #(
  parameter int NUM_MGR = 4,
  parameter int CNTL_W  = 2,
  parameter int TYPE_W  = 2,
  parameter int DATA_W  = 64,
  parameter int OOB_W   = 32
);
  logic [NUM_MGR-1:0]        mgr__arb__valid;
  logic [NUM_MGR*CNTL_W-1:0] mgr__arb__cntl;
  logic [NUM_MGR*TYPE_W-1:0] mgr__arb__type;
  logic [NUM_MGR*DATA_W-1:0] mgr__arb__data;
  logic [NUM_MGR*OOB_W-1:0]  mgr__arb__oob_data;
  logic [NUM_MGR-1:0]        arb__mgr__ready;

  logic                      arb__stu__valid;
  logic [CNTL_W-1:0]         arb__stu__cntl;
  logic [TYPE_W-1:0]         arb__stu__type;
  logic [DATA_W-1:0]         arb__stu__data;
  logic [OOB_W-1:0]          arb__stu__oob_data;
  logic                      stu__arb__ready;

  modport master (
    input  mgr__arb__valid, mgr__arb__cntl, mgr__arb__type,
           mgr__arb__data, mgr__arb__oob_data, stu__arb__ready,
    output arb__mgr__ready, arb__stu__valid, arb__stu__cntl,
           arb__stu__type, arb__stu__data, arb__stu__oob_data
  );

  modport slave (
    output mgr__arb__valid, mgr__arb__cntl, mgr__arb__type,
           mgr__arb__data, mgr__arb__oob_data, stu__arb__ready,
    input  arb__mgr__ready, arb__stu__valid, arb__stu__cntl,
           arb__stu__type, arb__stu__data, arb__stu__oob_data
  );
endinterface

// File: rtl/mgr_stu_arbiter.sv
// Round-robin, packet-atomic arbiter: one Manager owns the upstream port from SOM
// until its EOM beat is accepted, with a one-entry output register in between.
module mgr_stu_arbiter #(
  parameter int NUM_MGR = 4,
  parameter int CNTL_W  = 2,
  parameter int TYPE_W  = 2,
  parameter int DATA_W  = 64,
  parameter int OOB_W   = 32,
  parameter int MGR_W   = $clog2(NUM_MGR)
) (
  input  logic                 clk,
  input  logic                 reset_poweron,
  mgr_stu_arbiter_if.master    bus,
  output logic [MGR_W-1:0]     arb__sys__grant_id,
  output logic [15:0]          arb__sys__pkt_count,
  output logic                 arb__sys__proto_err
);
  localparam logic [CNTL_W-1:0] CNTL_MOM     = CNTL_W'(2'b00);
  localparam logic [CNTL_W-1:0] CNTL_SOM     = CNTL_W'(2'b01);
  localparam logic [CNTL_W-1:0] CNTL_EOM     = CNTL_W'(2'b10);
  localparam logic [CNTL_W-1:0] CNTL_SOM_EOM = CNTL_W'(2'b11);

  typedef enum logic {ST_IDLE, ST_LOCKED} state_t;

  state_t              r_state;
  state_t              w_nextState;
  logic [MGR_W-1:0]    r_grantId;
  logic [MGR_W-1:0]    r_rrPtr;
  logic [15:0]         r_pktCount;
  logic                r_protoErr;

  logic                r_outValid;
  logic [CNTL_W-1:0]   r_outCntl;
  logic [TYPE_W-1:0]   r_outType;
  logic [DATA_W-1:0]   r_outData;
  logic [OOB_W-1:0]    r_outOob;

  logic [CNTL_W-1:0]   w_cntl [NUM_MGR];
  logic [TYPE_W-1:0]   w_type [NUM_MGR];
  logic [DATA_W-1:0]   w_data [NUM_MGR];
  logic [OOB_W-1:0]    w_oob  [NUM_MGR];
  logic [NUM_MGR-1:0]  w_isSom;
  logic [NUM_MGR-1:0]  w_isCont;

  logic                w_hit;
  logic [MGR_W-1:0]    w_hitIdx;
  logic                w_ready;
  logic                w_accept;
  logic [CNTL_W-1:0]   w_selCntl;
  logic                w_selEom;
  logic                w_idleErr;
  logic                w_lockErr;

  function automatic logic [MGR_W-1:0] wrapIdx(input logic [MGR_W-1:0] base, input int off);
    int sum;
    sum = int'(base) + off;
    if (sum >= NUM_MGR) sum = sum - NUM_MGR;
    return sum[MGR_W-1:0];
  endfunction

  always_comb begin
    w_isSom  = '0;
    w_isCont = '0;
    for (int i = 0; i < NUM_MGR; i++) begin
      w_cntl[i] = bus.mgr__arb__cntl[i*CNTL_W +: CNTL_W];
      w_type[i] = bus.mgr__arb__type[i*TYPE_W +: TYPE_W];
      w_data[i] = bus.mgr__arb__data[i*DATA_W +: DATA_W];
      w_oob[i]  = bus.mgr__arb__oob_data[i*OOB_W +: OOB_W];
      w_isSom[i]  = bus.mgr__arb__valid[i] &&
                    (w_cntl[i] == CNTL_SOM || w_cntl[i] == CNTL_SOM_EOM);
      w_isCont[i] = bus.mgr__arb__valid[i] &&
                    (w_cntl[i] == CNTL_MOM || w_cntl[i] == CNTL_EOM);
    end
  end

  // First packet start at or after the round-robin pointer wins.
  always_comb begin
    w_hit    = 1'b0;
    w_hitIdx = '0;
    for (int k = 0; k < NUM_MGR; k++) begin
      if (!w_hit && w_isSom[wrapIdx(r_rrPtr, k)]) begin
        w_hit    = 1'b1;
        w_hitIdx = wrapIdx(r_rrPtr, k);
      end
    end
  end

  assign w_selCntl = w_cntl[r_grantId];
  assign w_selEom  = (w_selCntl == CNTL_EOM) || (w_selCntl == CNTL_SOM_EOM);

  always_ff @(posedge clk or posedge reset_poweron) begin
    if (reset_poweron) r_state <= ST_IDLE;
    else               r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    w_ready     = 1'b0;
    w_accept    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_hit) w_nextState = ST_LOCKED;
      end
      ST_LOCKED: begin
        w_ready  = !r_outValid || bus.stu__arb__ready;
        w_accept = w_ready && bus.mgr__arb__valid[r_grantId];
        if (w_accept && w_selEom) w_nextState = ST_IDLE;
      end
      default: w_nextState = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.arb__mgr__ready = '0;
    if (w_ready) bus.arb__mgr__ready[r_grantId] = 1'b1;
  end

  assign w_idleErr = (r_state == ST_IDLE) && (|w_isCont);
  assign w_lockErr = w_accept && (w_selCntl == CNTL_SOM);

  // Pointer and packet count advance when the EOM is taken in, not when it drains.
  always_ff @(posedge clk or posedge reset_poweron) begin
    if (reset_poweron) begin
      r_grantId  <= '0;
      r_rrPtr    <= '0;
      r_pktCount <= '0;
      r_protoErr <= 1'b0;
    end else begin
      if (r_state == ST_IDLE && w_hit) r_grantId <= w_hitIdx;
      if (w_accept && w_selEom) begin
        r_rrPtr    <= wrapIdx(r_grantId, 1);
        r_pktCount <= r_pktCount + 16'd1;
      end
      if (w_idleErr || w_lockErr) r_protoErr <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset_poweron) begin
    if (reset_poweron) begin
      r_outValid <= 1'b0;
      r_outCntl  <= '0;
      r_outType  <= '0;
      r_outData  <= '0;
      r_outOob   <= '0;
    end else if (w_accept) begin
      r_outValid <= 1'b1;
      r_outCntl  <= w_selCntl;
      r_outType  <= w_type[r_grantId];
      r_outData  <= w_data[r_grantId];
      r_outOob   <= w_oob[r_grantId];
    end else if (bus.stu__arb__ready) begin
      r_outValid <= 1'b0;
    end
  end

  assign bus.arb__stu__valid    = r_outValid;
  assign bus.arb__stu__cntl     = r_outCntl;
  assign bus.arb__stu__type     = r_outType;
  assign bus.arb__stu__data     = r_outData;
  assign bus.arb__stu__oob_data = r_outOob;

  assign arb__sys__grant_id  = r_grantId;
  assign arb__sys__pkt_count = r_pktCount;
  assign arb__sys__proto_err = r_protoErr;
endmodule

// File: tb/tb_mgr_stu_arbiter.sv
// Directed bench for mgr_stu_arbiter: arbitration order, backpressure, protocol
// errors, asynchronous reset mid-packet and packet-counter wrap.
module tb_mgr_stu_arbiter;
  localparam logic [1:0] MOM     = 2'b00;
  localparam logic [1:0] SOM     = 2'b01;
  localparam logic [1:0] EOM     = 2'b10;
  localparam logic [1:0] SOM_EOM = 2'b11;

  logic        clk;
  logic        rst;
  logic [1:0]  grantId;
  logic [15:0] pktCount;
  logic        protoErr;
  int          nChecks;
  int          nFails;

  mgr_stu_arbiter_if #(.NUM_MGR(4), .CNTL_W(2), .TYPE_W(2), .DATA_W(64), .OOB_W(32)) bus ();

  mgr_stu_arbiter #(.NUM_MGR(4), .CNTL_W(2), .TYPE_W(2), .DATA_W(64), .OOB_W(32)) dut (
    .clk                 (clk),
    .reset_poweron       (rst),
    .bus                 (bus),
    .arb__sys__grant_id  (grantId),
    .arb__sys__pkt_count (pktCount),
    .arb__sys__proto_err (protoErr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    nChecks++;
    assert (observed === expected) else begin
      nFails++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input int idx, input logic v, input logic [1:0] cntl, input logic [63:0] data);
    bus.mgr__arb__valid[idx]            = v;
    bus.mgr__arb__cntl[idx*2 +: 2]      = cntl;
    bus.mgr__arb__type[idx*2 +: 2]      = 2'(idx);
    bus.mgr__arb__data[idx*64 +: 64]    = data;
    bus.mgr__arb__oob_data[idx*32 +: 32] = data[31:0] ^ 32'hC0DE_0000;
  endtask

  task automatic nextCycle();
    @(negedge clk);
  endtask

  task automatic checkBeat(input string tag, input logic [63:0] data, input logic [1:0] cntl);
    checkOutput({tag, "_valid"}, 64'(bus.arb__stu__valid), 64'd1);
    checkOutput({tag, "_data"},  bus.arb__stu__data, data);
    checkOutput({tag, "_cntl"},  64'(bus.arb__stu__cntl), 64'(cntl));
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog expired before end of test");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    nChecks = 0;
    nFails  = 0;
    rst = 1'b1;
    bus.mgr__arb__valid    = '0;
    bus.mgr__arb__cntl     = '0;
    bus.mgr__arb__type     = '0;
    bus.mgr__arb__data     = '0;
    bus.mgr__arb__oob_data = '0;
    bus.stu__arb__ready    = 1'b1;
    nextCycle();
    nextCycle();
    checkOutput("rst_valid", 64'(bus.arb__stu__valid), 64'd0);
    checkOutput("rst_data",  bus.arb__stu__data, 64'd0);
    checkOutput("rst_ready", 64'(bus.arb__mgr__ready), 64'd0);
    checkOutput("rst_pkt",   64'(pktCount), 64'd0);
    checkOutput("rst_err",   64'(protoErr), 64'd0);
    checkOutput("rst_grant", 64'(grantId), 64'd0);
    rst = 1'b0;

    // Single 3-beat packet from Manager 2, then rr pointer check via 0 vs 3.
    applyStimulus(2, 1'b1, SOM, 64'hA0);
    #1 checkOutput("t1_idle_ready", 64'(bus.arb__mgr__ready), 64'd0);
    nextCycle();
    checkOutput("t1_grant", 64'(grantId), 64'd2);
    checkOutput("t1_ready", 64'(bus.arb__mgr__ready), 64'b0100);
    checkOutput("t1_prefill_valid", 64'(bus.arb__stu__valid), 64'd0);
    nextCycle();
    checkBeat("t1_b0", 64'hA0, SOM);
    checkOutput("t1_b0_type", 64'(bus.arb__stu__type), 64'd2);
    checkOutput("t1_b0_oob", 64'(bus.arb__stu__oob_data), 64'hC0DE_00A0);
    applyStimulus(2, 1'b1, MOM, 64'hA1);
    nextCycle();
    checkBeat("t1_b1", 64'hA1, MOM);
    applyStimulus(2, 1'b1, EOM, 64'hA2);
    nextCycle();
    checkBeat("t1_b2", 64'hA2, EOM);
    checkOutput("t1_pkt", 64'(pktCount), 64'd1);
    applyStimulus(2, 1'b0, MOM, 64'h0);
    applyStimulus(0, 1'b1, SOM_EOM, 64'hB0);
    applyStimulus(3, 1'b1, SOM_EOM, 64'hB3);
    #1 checkOutput("t1_idle_ready2", 64'(bus.arb__mgr__ready), 64'd0);
    nextCycle();
    checkOutput("t1_rr_grant3", 64'(grantId), 64'd3);
    checkOutput("t1_drained", 64'(bus.arb__stu__valid), 64'd0);
    nextCycle();
    checkBeat("t1_b3", 64'hB3, SOM_EOM);
    checkOutput("t1_pkt2", 64'(pktCount), 64'd2);
    applyStimulus(3, 1'b0, SOM_EOM, 64'h0);
    nextCycle();
    checkOutput("t1_rr_grant0", 64'(grantId), 64'd0);
    nextCycle();
    checkBeat("t1_bb0", 64'hB0, SOM_EOM);
    checkOutput("t1_pkt3", 64'(pktCount), 64'd3);
    applyStimulus(0, 1'b0, SOM_EOM, 64'h0);

    // All four Managers request together right after reset.
    rst = 1'b1;
    nextCycle();
    rst = 1'b0;
    checkOutput("t2_pkt_rst", 64'(pktCount), 64'd0);
    for (int m = 0; m < 4; m++) applyStimulus(m, 1'b1, SOM_EOM, 64'hC0 + 64'(m));
    for (int g = 0; g < 4; g++) begin
      nextCycle();
      checkOutput($sformatf("t2_grant%0d", g), 64'(grantId), 64'(g));
      checkOutput($sformatf("t2_bubble%0d", g), 64'(bus.arb__stu__valid), 64'd0);
      nextCycle();
      checkBeat($sformatf("t2_beat%0d", g), 64'hC0 + 64'(g), SOM_EOM);
      checkOutput($sformatf("t2_pkt%0d", g), 64'(pktCount), 64'(g + 1));
      applyStimulus(g, 1'b0, SOM_EOM, 64'h0);
    end

    // Upstream stalls for 5 cycles with the register full.
    applyStimulus(1, 1'b1, SOM, 64'hE0);
    nextCycle();
    checkOutput("t3_grant", 64'(grantId), 64'd1);
    nextCycle();
    checkBeat("t3_b0", 64'hE0, SOM);
    applyStimulus(1, 1'b1, MOM, 64'hE1);
    bus.stu__arb__ready = 1'b0;
    #1 checkOutput("t3_ready_full", 64'(bus.arb__mgr__ready), 64'd0);
    for (int k = 0; k < 4; k++) begin
      nextCycle();
      checkBeat($sformatf("t3_stall%0d", k), 64'hE0, SOM);
      checkOutput($sformatf("t3_stall_ready%0d", k), 64'(bus.arb__mgr__ready), 64'd0);
    end
    nextCycle();
    checkBeat("t3_stall_last", 64'hE0, SOM);
    bus.stu__arb__ready = 1'b1;
    #1 checkOutput("t3_ready_resume", 64'(bus.arb__mgr__ready), 64'b0010);
    nextCycle();
    checkBeat("t3_b1", 64'hE1, MOM);
    applyStimulus(1, 1'b1, EOM, 64'hE2);
    nextCycle();
    checkBeat("t3_b2", 64'hE2, EOM);
    checkOutput("t3_pkt", 64'(pktCount), 64'd5);
    applyStimulus(1, 1'b0, MOM, 64'h0);
    nextCycle();
    checkOutput("t3_empty", 64'(bus.arb__stu__valid), 64'd0);

    // Orphan EOM from Manager 1 while Manager 3 starts a real packet.
    applyStimulus(1, 1'b1, EOM, 64'h11);
    applyStimulus(3, 1'b1, SOM_EOM, 64'h33);
    nextCycle();
    checkOutput("t4_grant", 64'(grantId), 64'd3);
    checkOutput("t4_err", 64'(protoErr), 64'd1);
    nextCycle();
    checkBeat("t4_beat", 64'h33, SOM_EOM);
    checkOutput("t4_pkt", 64'(pktCount), 64'd6);
    applyStimulus(3, 1'b0, SOM_EOM, 64'h0);
    nextCycle();
    checkOutput("t4_no_grant", 64'(grantId), 64'd3);
    checkOutput("t4_ready", 64'(bus.arb__mgr__ready), 64'd0);
    nextCycle();
    checkOutput("t4_no_grant2", 64'(grantId), 64'd3);
    checkOutput("t4_valid", 64'(bus.arb__stu__valid), 64'd0);
    checkOutput("t4_err_sticky", 64'(protoErr), 64'd1);
    applyStimulus(1, 1'b0, EOM, 64'h0);

    // Asynchronous reset during the second beat, then a fresh packet.
    applyStimulus(0, 1'b1, SOM, 64'hD0);
    nextCycle();
    checkOutput("t5_grant", 64'(grantId), 64'd0);
    nextCycle();
    checkBeat("t5_b0", 64'hD0, SOM);
    applyStimulus(0, 1'b1, MOM, 64'hD1);
    #2 rst = 1'b1;
    #1;
    checkOutput("t5_rst_valid", 64'(bus.arb__stu__valid), 64'd0);
    checkOutput("t5_rst_ready", 64'(bus.arb__mgr__ready), 64'd0);
    checkOutput("t5_rst_pkt",   64'(pktCount), 64'd0);
    checkOutput("t5_rst_err",   64'(protoErr), 64'd0);
    checkOutput("t5_rst_data",  bus.arb__stu__data, 64'd0);
    applyStimulus(0, 1'b0, MOM, 64'h0);
    nextCycle();
    rst = 1'b0;
    applyStimulus(0, 1'b1, SOM, 64'hD8);
    nextCycle();
    checkOutput("t5_regrant", 64'(grantId), 64'd0);
    checkOutput("t5_err_clear", 64'(protoErr), 64'd0);
    nextCycle();
    checkBeat("t5_b8", 64'hD8, SOM);
    applyStimulus(0, 1'b1, SOM, 64'hD9);
    nextCycle();
    checkBeat("t5_b9", 64'hD9, SOM);
    checkOutput("t5_som_err", 64'(protoErr), 64'd1);
    checkOutput("t5_lock_kept", 64'(bus.arb__mgr__ready), 64'b0001);
    applyStimulus(0, 1'b1, EOM, 64'hDA);
    nextCycle();
    checkBeat("t5_bA", 64'hDA, EOM);
    checkOutput("t5_pkt", 64'(pktCount), 64'd1);
    applyStimulus(0, 1'b0, EOM, 64'h0);

    // Counter preloaded to its maximum, then one more packet wraps it.
    nextCycle();
    force dut.r_pktCount = 16'hFFFF;
    #1 release dut.r_pktCount;
    applyStimulus(2, 1'b1, SOM_EOM, 64'hF2);
    nextCycle();
    checkOutput("t6_grant", 64'(grantId), 64'd2);
    nextCycle();
    checkBeat("t6_beat", 64'hF2, SOM_EOM);
    checkOutput("t6_pkt_wrap", 64'(pktCount), 64'd0);
    applyStimulus(2, 1'b0, SOM_EOM, 64'h0);
    nextCycle();

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end
endmodule
